// File: rtl/sram_arbiter.sv
// Shares one fixed-latency single-port SRAM between a read-only fetch port and a
// read/write MEM port. Define ARB_ROUND_ROBIN_EN for round-robin grant on contention.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_r_req,
    input  logic              mem_w_req,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_en,
    output logic              sram_we,
    input  logic [31:0]       sram_rdata,
    output logic              freeze
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_mem_q, grant_mem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;

    logic              mem_req;
    logic              any_req;
    logic              pick_mem;
    logic [31:0]       mem_off;
    logic [ADDR_W-1:0] mem_word;
    logic [ADDR_W-1:0] if_word;
    logic              unused_addr_bits;

    assign mem_req  = mem_r_req | mem_w_req;
    assign any_req  = mem_req | if_req;
    assign mem_off  = mem_addr - 32'(BASE_ADDR);
    assign mem_word = mem_off[ADDR_W+1:2];
    assign if_word  = if_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{mem_off[1:0], mem_off[31:ADDR_W+2],
                                if_addr[1:0], if_addr[31:ADDR_W+2]};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_mem_q;

    // Reset to IF so that MEM wins the first contended grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_mem_q <= 1'b0;
        end else if (state_q == StIdle && any_req) begin
            last_mem_q <= pick_mem;
        end
    end

    assign pick_mem = mem_req & (~if_req | ~last_mem_q);
`else
    assign pick_mem = mem_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            grant_mem_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_mem_q <= grant_mem_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_mem_d = grant_mem_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_mem_d = pick_mem;
                    addr_d      = pick_mem ? mem_word : if_word;
                    wdata_d     = pick_mem ? mem_wdata : '0;
                    // Both MEM flags high resolves to a write.
                    we_d        = pick_mem & mem_w_req;
                    cnt_d       = 4'(WAIT_CYCLES - 1);
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (grant_mem_q) begin
                            mem_rdata_d = sram_rdata;
                        end else begin
                            if_rdata_d = sram_rdata;
                        end
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign if_ready   = (state_q == StDone) & ~grant_mem_q;
    assign mem_ready  = (state_q == StDone) & grant_mem_q;
    assign sram_en    = (state_q == StAccess);
    assign sram_we    = (state_q == StAccess) & we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    // Gated by rst so every output reads 0 while reset is held.
    assign freeze = rst & ((if_req & ~if_ready) | (mem_req & ~mem_ready));

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model of grant order, latency and SRAM contents.
module tb_sram_arbiter;

    localparam int W0   = 4;
    localparam int W1   = 1;
    localparam int BASE = 1024;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_r_req, mem_w_req;
    logic [31:0] if_addr, mem_addr, mem_wdata;

    logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
    logic        if_ready, mem_ready, sram_en, sram_we, freeze;
    logic [15:0] sram_addr;

    logic [31:0] w1_if_rdata, w1_mem_rdata, w1_sram_wdata, w1_sram_rdata;
    logic        w1_if_ready, w1_mem_ready, w1_sram_en, w1_sram_we, w1_freeze;
    logic [15:0] w1_sram_addr;

    int n_cmp = 0;
    int n_bad = 0;
    bit rr_last_mem;

    logic [31:0] mem0 [256];
    bit          val0 [256];
    logic [31:0] mem1 [256];
    bit          val1 [256];
    logic [31:0] ref_mem [256];
    bit          ref_val [256];

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W0), .ADDR_W(16), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_r_req(mem_r_req), .mem_w_req(mem_w_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_en(sram_en),
        .sram_we(sram_we), .sram_rdata(sram_rdata), .freeze(freeze)
    );

    sram_arbiter #(.WAIT_CYCLES(W1), .ADDR_W(16), .BASE_ADDR(BASE)) dut_w1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(w1_if_rdata), .if_ready(w1_if_ready),
        .mem_r_req(mem_r_req), .mem_w_req(mem_w_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(w1_mem_rdata), .mem_ready(w1_mem_ready),
        .sram_addr(w1_sram_addr), .sram_wdata(w1_sram_wdata), .sram_en(w1_sram_en),
        .sram_we(w1_sram_we), .sram_rdata(w1_sram_rdata), .freeze(w1_freeze)
    );

    // Unwritten SRAM words return a per-address pattern.
    function automatic logic [31:0] fill(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    assign sram_rdata    = val0[sram_addr[7:0]] ? mem0[sram_addr[7:0]] : fill(sram_addr[7:0]);
    assign w1_sram_rdata = val1[w1_sram_addr[7:0]] ? mem1[w1_sram_addr[7:0]]
                                                   : fill(w1_sram_addr[7:0]);

    always @(posedge clk) begin
        if (sram_en && sram_we) begin
            mem0[sram_addr[7:0]] <= sram_wdata;
            val0[sram_addr[7:0]] <= 1'b1;
        end
        if (w1_sram_en && w1_sram_we) begin
            mem1[w1_sram_addr[7:0]] <= w1_sram_wdata;
            val1[w1_sram_addr[7:0]] <= 1'b1;
        end
    end

    function automatic logic [31:0] ref_read(input logic [7:0] w);
        return ref_val[w] ? ref_mem[w] : fill(w);
    endfunction

    task automatic ref_write(input logic [7:0] w, input logic [31:0] d);
        ref_mem[w] = d;
        ref_val[w] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        if_req = 0; mem_r_req = 0; mem_w_req = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        rr_last_mem = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            #1;
            if_req = 1'($urandom); mem_r_req = 1'($urandom); mem_w_req = 1'($urandom);
            if_addr = $urandom; mem_addr = $urandom; mem_wdata = $urandom;
            @(negedge clk);
            n_cmp++;
            if ({if_rdata, if_ready, mem_rdata, mem_ready, sram_addr, sram_wdata,
                 sram_en, sram_we, freeze} !== '0)
                begin n_bad++; $display("FAIL reset c%0d: en=%b rdy=%b/%b frz=%b, want all 0",
                                        i, sram_en, if_ready, mem_ready, freeze); end
            n_cmp++;
            if ({w1_if_rdata, w1_if_ready, w1_mem_rdata, w1_mem_ready, w1_sram_addr,
                 w1_sram_wdata, w1_sram_en, w1_sram_we, w1_freeze} !== '0)
                begin n_bad++; $display("FAIL reset_w1 c%0d: outputs not all 0", i); end
            @(posedge clk);
        end
    endtask

    task automatic test_if_read();
        logic [31:0] exp_d;
        do_reset();
        exp_d = ref_read(8'd4);
        if_req = 1; if_addr = 32'h10;
        for (int c = 0; c <= W0 + 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sram_en !== (c >= 1 && c <= W0))
                begin n_bad++; $display("FAIL if_read c%0d sram_en: got %b", c, sram_en); end
            n_cmp++;
            if (if_ready !== (c == W0 + 1) || mem_ready !== 1'b0)
                begin n_bad++; $display("FAIL if_read c%0d ready: got if=%b mem=%b",
                                        c, if_ready, mem_ready); end
            n_cmp++;
            if (freeze !== (c <= W0))
                begin n_bad++; $display("FAIL if_read c%0d freeze: got %b", c, freeze); end
            if (c >= 1 && c <= W0) begin
                n_cmp++;
                if (sram_addr !== 16'h4 || sram_we !== 1'b0)
                    begin n_bad++; $display("FAIL if_read c%0d addr/we: got %h/%b want 4/0",
                                            c, sram_addr, sram_we); end
            end
            if (c == W0 + 1) begin
                n_cmp++;
                if (if_rdata !== exp_d)
                    begin n_bad++; $display("FAIL if_read rdata: got %h want %h", if_rdata, exp_d); end
            end
            step();
            if (c == W0 + 1) if_req = 0;
        end
    endtask

    task automatic test_mem_write();
        do_reset();
        mem_w_req = 1; mem_addr = BASE + 8; mem_wdata = 32'hDEADBEEF;
        ref_write(8'd2, 32'hDEADBEEF);
        for (int c = 0; c <= W0 + 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_ready !== (c == W0 + 1) || if_ready !== 1'b0)
                begin n_bad++; $display("FAIL mem_write c%0d ready: got mem=%b if=%b",
                                        c, mem_ready, if_ready); end
            if (c >= 1 && c <= W0) begin
                n_cmp++;
                if (sram_en !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 16'h2 ||
                    sram_wdata !== 32'hDEADBEEF)
                    begin n_bad++; $display("FAIL mem_write c%0d bus: en=%b we=%b a=%h d=%h",
                                            c, sram_en, sram_we, sram_addr, sram_wdata); end
            end
            step();
            if (c == W0 + 1) mem_w_req = 0;
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_m, exp_i;
        int last_c;
        do_reset();
        exp_m = ref_read(8'd5);
        exp_i = ref_read(8'd9);
        mem_r_req = 1; mem_addr = BASE + 4 * 5;
        if_req = 1; if_addr = 4 * 9;
        last_c = RR ? 3 * W0 + 5 : 2 * W0 + 3;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_ready !== (c == W0 + 1 || (RR && c == 3 * W0 + 5)) ||
                if_ready !== (c == 2 * W0 + 3))
                begin n_bad++; $display("FAIL contention c%0d ready: got mem=%b if=%b",
                                        c, mem_ready, if_ready); end
            if (mem_ready === 1'b1) begin
                n_cmp++;
                if (mem_rdata !== exp_m)
                    begin n_bad++; $display("FAIL contention mem_rdata: got %h want %h",
                                            mem_rdata, exp_m); end
            end
            if (if_ready === 1'b1) begin
                n_cmp++;
                if (if_rdata !== exp_i)
                    begin n_bad++; $display("FAIL contention if_rdata: got %h want %h",
                                            if_rdata, exp_i); end
            end
            step();
            if (!RR && c == W0 + 1) mem_r_req = 0;
            if (c == 2 * W0 + 3) if_req = 0;
        end
        mem_r_req = 0;
    endtask

    task automatic test_drop();
        logic [31:0] exp_d;
        do_reset();
        exp_d = ref_read(8'd7);
        mem_r_req = 1; mem_addr = BASE + 4 * 7;
        for (int c = 0; c <= W0 + 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_ready !== (c == W0 + 1))
                begin n_bad++; $display("FAIL drop c%0d mem_ready: got %b", c, mem_ready); end
            n_cmp++;
            if (freeze !== (c <= 1))
                begin n_bad++; $display("FAIL drop c%0d freeze: got %b", c, freeze); end
            if (c == W0 + 1) begin
                n_cmp++;
                if (mem_rdata !== exp_d)
                    begin n_bad++; $display("FAIL drop rdata: got %h want %h", mem_rdata, exp_d); end
            end
            step();
            if (c == 1) mem_r_req = 0;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1; if_addr = 4 * 3;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sram_en !== (c == 1) || if_ready !== 1'b0 || mem_ready !== 1'b0)
                begin n_bad++; $display("FAIL reset_mid c%0d: en=%b rdy=%b/%b",
                                        c, sram_en, if_ready, mem_ready); end
            step();
            if (c == 1) begin rst = 0; if_req = 0; end
            if (c == 3) rst = 1;
        end
        if_req = 1; if_addr = 4 * 3;
        for (int c = 0; c <= W0 + 1; c++) begin
            @(negedge clk);
            n_cmp++;
            if (if_ready !== (c == W0 + 1))
                begin n_bad++; $display("FAIL reset_mid resume c%0d if_ready: got %b", c, if_ready); end
            step();
        end
        if_req = 0;
    endtask

    task automatic test_random();
        bit          use_if, has_mem, is_wr, mem_first;
        int          mk, mem_done, if_done, end_c;
        logic [7:0]  iw, mw;
        logic [31:0] wd, exp_m, exp_i;
        bit          exp_frz;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            use_if = 1'($urandom_range(0, 1));
            mk = $urandom_range(0, 3);
            if (!use_if && mk == 0) mk = $urandom_range(1, 3);
            has_mem = (mk != 0);
            is_wr = (mk >= 2);
            iw = 8'($urandom_range(0, 63));
            mw = 8'($urandom_range(0, 63));
            wd = $urandom;

            mem_first = (has_mem && use_if) ? (RR ? !rr_last_mem : 1'b1) : has_mem;
            mem_done = -1; if_done = -1; exp_m = '0; exp_i = '0;
            if (mem_first) begin
                mem_done = W0 + 1;
                if (is_wr) ref_write(mw, wd); else exp_m = ref_read(mw);
                if (use_if) begin if_done = 2 * W0 + 3; exp_i = ref_read(iw); end
                rr_last_mem = !use_if;
            end else begin
                if_done = W0 + 1;
                exp_i = ref_read(iw);
                if (has_mem) begin
                    mem_done = 2 * W0 + 3;
                    if (is_wr) ref_write(mw, wd); else exp_m = ref_read(mw);
                end
                rr_last_mem = has_mem;
            end
            end_c = (mem_done > if_done) ? mem_done : if_done;

            if_req = use_if; if_addr = {22'd0, iw, 2'b00};
            mem_r_req = (mk == 1 || mk == 3); mem_w_req = is_wr;
            mem_addr = BASE + 4 * int'(mw); mem_wdata = wd;
            for (int c = 0; c <= end_c; c++) begin
                @(negedge clk);
                n_cmp++;
                if (mem_ready !== (c == mem_done) || if_ready !== (c == if_done))
                    begin n_bad++; $display("FAIL random t%0d c%0d ready: got mem=%b if=%b want %0d/%0d",
                                            t, c, mem_ready, if_ready, mem_done, if_done); end
                exp_frz = (use_if && c < if_done) || (has_mem && c < mem_done);
                n_cmp++;
                if (freeze !== exp_frz)
                    begin n_bad++; $display("FAIL random t%0d c%0d freeze: got %b want %b",
                                            t, c, freeze, exp_frz); end
                if (c == mem_done && !is_wr) begin
                    n_cmp++;
                    if (mem_rdata !== exp_m)
                        begin n_bad++; $display("FAIL random t%0d mem_rdata: got %h want %h",
                                                t, mem_rdata, exp_m); end
                end
                if (c == if_done) begin
                    n_cmp++;
                    if (if_rdata !== exp_i)
                        begin n_bad++; $display("FAIL random t%0d if_rdata: got %h want %h",
                                                t, if_rdata, exp_i); end
                end
                step();
                if (c == mem_done) begin mem_r_req = 0; mem_w_req = 0; end
                if (c == if_done) if_req = 0;
            end
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic test_wait1();
        logic [31:0] wd;
        do_reset();
        wd = $urandom;
        mem_r_req = 1; mem_w_req = 1; mem_addr = BASE + 4 * 11; mem_wdata = wd;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (w1_mem_ready !== (c == 2))
                begin n_bad++; $display("FAIL wait1 wr c%0d mem_ready: got %b", c, w1_mem_ready); end
            n_cmp++;
            if (w1_sram_en !== (c == 1) || w1_sram_we !== (c == 1))
                begin n_bad++; $display("FAIL wait1 wr c%0d en/we: got %b/%b",
                                        c, w1_sram_en, w1_sram_we); end
            if (c == 1) begin
                n_cmp++;
                if (w1_sram_addr !== 16'd11 || w1_sram_wdata !== wd)
                    begin n_bad++; $display("FAIL wait1 wr bus: a=%h d=%h want b/%h",
                                            w1_sram_addr, w1_sram_wdata, wd); end
            end
            step();
            if (c == 2) begin mem_r_req = 0; mem_w_req = 0; end
        end
        mem_r_req = 1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (w1_mem_ready !== (c == 2))
                begin n_bad++; $display("FAIL wait1 rd c%0d mem_ready: got %b", c, w1_mem_ready); end
            if (c == 2) begin
                n_cmp++;
                if (w1_mem_rdata !== wd)
                    begin n_bad++; $display("FAIL wait1 rd rdata: got %h want %h", w1_mem_rdata, wd); end
            end
            step();
        end
        mem_r_req = 0;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; mem_r_req = 0; mem_w_req = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        rr_last_mem = 1'b0;
        #2;
        test_reset();
        test_if_read();
        test_mem_write();
        test_contention();
        test_drop();
        test_reset_mid();
        test_random();
        test_wait1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
